// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the front end: fetch state encoding,
// instruction size and default reset vector, plus address helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instructions are word aligned; the low two address bits are always zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // Sequential fetch wraps modulo 2^32 with no overflow indication.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the synchronous
// instruction memory address and tags the returned word with its PC.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr_0,
  output logic [31:0] pc_out,
  output logic        bubble_out
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;

  assign mem_addr_0 = fetch_pc;

  // Priority: reset > halt > redirect > stall > sequential advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= word_align(RESET_PC);
      pc_out     <= '0;
      bubble_out <= 1'b1;
      state      <= BOOT;
    end else if (halt) begin
      fetch_pc   <= fetch_pc;
      pc_out     <= pc_out;
      bubble_out <= bubble_out;
      state      <= state;
    end else if (branch_taken) begin
      // The word currently returning from memory is on the wrong path.
      fetch_pc   <= word_align(branch_target);
      bubble_out <= 1'b1;
      state      <= REDIRECT;
    end else if (!stall) begin
      pc_out     <= fetch_pc;
      fetch_pc   <= next_pc(fetch_pc);
      bubble_out <= 1'b0;
      case (state)
        RUN:            state <= RUN;
        BOOT, REDIRECT: state <= RUN;
        default:        state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: stimulus pushes hand-computed expected
// outputs into a queue, an independent monitor pops and compares each cycle.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_addr_0;
  logic [31:0] pc_out;
  logic        bubble_out;

  typedef struct {
    string       name;
    logic [31:0] mem;
    logic [31:0] pc;
    logic        bub;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_addr_0    (mem_addr_0),
    .pc_out        (pc_out),
    .bubble_out    (bubble_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then record what the outputs must be after the edge.
  task automatic cyc(input string name, input logic rn, input logic h, input logic s,
                     input logic bt, input logic [31:0] tgt,
                     input logic [31:0] em, input logic [31:0] ep, input logic eb);
    exp_t e;
    @(negedge clk);
    rst_n = rn; halt = h; stall = s; branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    e.name = name; e.mem = em; e.pc = ep; e.bub = eb;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are register-driven, so the negedge is a stable sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mem_addr_0 !== e.mem) begin
          errors++;
          $display("FAIL %s mem_addr_0: got %h expected %h", e.name, mem_addr_0, e.mem);
        end
        checks++;
        if (pc_out !== e.pc) begin
          errors++;
          $display("FAIL %s pc_out: got %h expected %h", e.name, pc_out, e.pc);
        end
        checks++;
        if (bubble_out !== e.bub) begin
          errors++;
          $display("FAIL %s bubble_out: got %b expected %b", e.name, bubble_out, e.bub);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    //   name            rn h  s  bt target         mem            pc             bub
    cyc("reset",         0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1);
    cyc("boot_edge",     1, 0, 0, 0, 32'h0,         32'h4,         32'h0,         0);
    cyc("run1",          1, 0, 0, 0, 32'h0,         32'h8,         32'h4,         0);
    cyc("run2",          1, 0, 0, 0, 32'h0,         32'hC,         32'h8,         0);
    cyc("run3",          1, 0, 0, 0, 32'h0,         32'h10,        32'hC,         0);
    // Stall three cycles at 0x10, then release.
    for (int unsigned i = 0; i < 3; i++)
      cyc("stall_hold",  1, 0, 1, 0, 32'h0,         32'h10,        32'hC,         0);
    cyc("stall_release", 1, 0, 0, 0, 32'h0,         32'h14,        32'h10,        0);
    // Redirect with unaligned target.
    cyc("branch_103",    1, 0, 0, 1, 32'h103,       32'h100,       32'h10,        1);
    cyc("after_branch",  1, 0, 0, 0, 32'h0,         32'h104,       32'h100,       0);
    // Redirect wins over stall; stall then holds the redirect state.
    cyc("branch_stall",  1, 0, 1, 1, 32'h200,       32'h200,       32'h100,       1);
    cyc("redir_stall1",  1, 0, 1, 0, 32'h0,         32'h200,       32'h100,       1);
    cyc("redir_stall2",  1, 0, 1, 0, 32'h0,         32'h200,       32'h100,       1);
    cyc("redir_release", 1, 0, 0, 0, 32'h0,         32'h204,       32'h200,       0);
    // Wrap-around at the top of the address space.
    cyc("branch_top",    1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h200,       1);
    cyc("wrap",          1, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 0);
    cyc("after_wrap",    1, 0, 0, 0, 32'h0,         32'h4,         32'h0,         0);
    // Halt in REDIRECT freezes everything, then reset overrides halt.
    cyc("branch_40",     1, 0, 0, 1, 32'h40,        32'h40,        32'h0,         1);
    cyc("halt_branch",   1, 1, 1, 1, 32'h80,        32'h40,        32'h0,         1);
    cyc("halt_free",     1, 1, 0, 0, 32'h0,         32'h40,        32'h0,         1);
    cyc("halt_reset",    0, 1, 1, 1, 32'h80,        32'h0,         32'h0,         1);
    cyc("boot_again",    1, 0, 0, 0, 32'h0,         32'h4,         32'h0,         0);
    // Redirect straight out of BOOT, then a back-to-back redirect.
    cyc("reset2",        0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1);
    cyc("boot_branch",   1, 0, 0, 1, 32'h30,        32'h30,        32'h0,         1);
    cyc("boot_br_next",  1, 0, 0, 0, 32'h0,         32'h34,        32'h30,        0);
    cyc("branch_50",     1, 0, 0, 1, 32'h52,        32'h50,        32'h30,        1);
    cyc("branch_60",     1, 0, 0, 1, 32'h61,        32'h60,        32'h30,        1);
    cyc("after_60",      1, 0, 0, 0, 32'h0,         32'h64,        32'h60,        0);
    // Reset during a stall+branch, then a stall while still in BOOT.
    cyc("reset_stall",   0, 0, 1, 1, 32'h90,        32'h0,         32'h0,         1);
    cyc("boot_stall",    1, 0, 1, 0, 32'h0,         32'h0,         32'h0,         1);
    cyc("boot_go",       1, 0, 0, 0, 32'h0,         32'h4,         32'h0,         0);
    cyc("run_go",        1, 0, 0, 0, 32'h0,         32'h8,         32'h4,         0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
